// File: rtl/dm_wait_ram.sv
// dm_wait_ram: data-memory responder with a programmable wait-state counter and a one-cycle ready pulse.
// Latency: accept edge to ready cycle is WAIT_CYCLES+1 clocks; throughput one transaction per WAIT_CYCLES+1 clocks.
// Backpressure: en is ignored while busy (WAIT); the initiator holds en until ready. Optional DM_BOUNDS_CHECK_EN adds err.
module dm_wait_ram #(
   parameter int DEPTH_WORDS = 1024,  // power of two, >= 4
   parameter int WAIT_CYCLES = 2      // 0..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy
`ifdef DM_BOUNDS_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      cnt;
   logic            accept;
   logic            commit;
   logic            req_oor;

   // request captured at acceptance, used when the commit happens later
   logic [AW-1:0]   lat_idx;
   logic [3:0]      lat_wen;
   logic [31:0]     lat_wdata;
   logic            lat_oor;

   // request actually applied at the commit edge
   logic [AW-1:0]   c_idx;
   logic [3:0]      c_wen;
   logic [31:0]     c_wdata;
   logic            c_oor;

   logic [31:0]     mem [DEPTH_WORDS];

   // Word-offset bits and (without bounds checking) the upper address bits
   // are deliberately ignored; with zero wait states the latched copy is never consumed.
   logic            unused_bits;
   assign unused_bits = ^{addr[1:0], addr[31:AW+2], lat_idx, lat_wen, lat_wdata, lat_oor};

`ifdef DM_BOUNDS_CHECK_EN
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   assign req_oor = ({1'b0, addr} >= LIMIT);
`else
   // Out-of-range addresses simply alias modulo the memory size.
   assign req_oor = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, acceptance and commit strobe; reset suppresses any commit so
   // a request pending in WAIT is discarded without touching the array.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (en) begin
               accept    = 1'b1;
               state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
               commit    = (WAIT_CYCLES == 0) && !reset;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               state_nxt = RESP;
               commit    = !reset;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Wait-state counter: loaded on acceptance, counts down while waiting
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= WAIT_LD;
      end else if (state == WAIT) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Capture the request at acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_idx   <= addr[AW+1:2];
         lat_wen   <= wen;
         lat_wdata <= wdata;
         lat_oor   <= req_oor;
      end
   end

   // With no wait states the commit coincides with acceptance, so the live
   // request is applied; otherwise the captured copy is.
   always_comb begin
      c_idx   = lat_idx;
      c_wen   = lat_wen;
      c_wdata = lat_wdata;
      c_oor   = lat_oor;
      if (WAIT_CYCLES == 0) begin
         c_idx   = addr[AW+1:2];
         c_wen   = wen;
         c_wdata = wdata;
         c_oor   = req_oor;
      end
   end

   // Byte-masked write port of the synchronous RAM
   always_ff @(posedge clk) begin
      if (commit && !c_oor) begin
         for (int b = 0; b < 4; b++) begin
            if (c_wen[b]) begin
               mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
         end
      end
   end

   // Registered read data; writes leave it holding the previous read
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (commit && (c_wen == 4'b0000)) begin
         rdata <= c_oor ? 32'h0 : mem[c_idx];
      end
   end

`ifdef DM_BOUNDS_CHECK_EN
   // Error flag, high only in the ready cycle of an out-of-range request
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= commit && c_oor;
      end
   end
`endif

   assign ready = (state == RESP);
   assign busy  = (state == WAIT);

endmodule

// File: tb/tb_dm_wait_ram.sv
// tb_dm_wait_ram: scoreboard bench for dm_wait_ram, one instance with two wait states and one with none.
// Latency: checks accept-to-ready distance and busy width per transaction.
// Backpressure: en held until ready; expected responses queued at issue, compared on ready.
`timescale 1ns/1ps
module tb_dm_wait_ram;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic        en, en0;
   logic [3:0]  wen, wen0;
   logic [31:0] addr, addr0, wdata, wdata0;
   logic [31:0] rdata, rdata0;
   logic        ready, busy, ready0, busy0;
`ifdef DM_BOUNDS_CHECK_EN
   logic        err, err0;
`endif

   int          n_checks = 0;
   int          n_fails  = 0;

   exp_t        q2[$];
   exp_t        q0[$];
   exp_t        m2, m0;
   logic [31:0] model [1024];
   logic [31:0] last_rd;
   logic [31:0] vals [4];

   always #5 clk = ~clk;

   dm_wait_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy)
`ifdef DM_BOUNDS_CHECK_EN
      , .err(err)
`endif
   );

   dm_wait_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .en(en0), .wen(wen0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .ready(ready0), .busy(busy0)
`ifdef DM_BOUNDS_CHECK_EN
      , .err(err0)
`endif
   );

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference behaviour of one request against the bench's memory model
   function automatic exp_t predict(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      exp_t       e;
      logic [9:0] idx;
      logic       oor;
      idx = a[11:2];
      oor = 1'b0;
`ifdef DM_BOUNDS_CHECK_EN
      oor = ({1'b0, a} >= 33'd4096);
`endif
      if (w != 4'b0000) begin
         if (!oor) begin
            for (int b = 0; b < 4; b++) begin
               if (w[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
         end
         e.rdata = last_rd;
      end else begin
         e.rdata = oor ? 32'h0 : model[idx];
         last_rd = e.rdata;
      end
      e.err = oor;
      return e;
   endfunction

   // Drive one request on the two-wait-state instance; call at a negedge with
   // the block in IDLE or RESP. Returns at the ready negedge with en still high.
   task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input bit interfere);
      int cyc;
      int nbusy;
      q2.push_back(predict(w, a, d));
      en = 1'b1; wen = w; addr = a; wdata = d;
      @(posedge clk);
      cyc = 0;
      nbusy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) nbusy++;
         if (interfere && cyc == 1) en = 1'b0;
         if (interfere && cyc == 2) begin
            en = 1'b1; addr = a ^ 32'h30; wen = 4'hF; wdata = 32'hBAD0BAD0;
         end
      end while (!ready && cyc < 40);
      chk_eq("ready_seen", ready, 1);
      chk_eq("latency", cyc, 3);
      chk_eq("busy_cycles", nbusy, 2);
   endtask

   task automatic idle();
      en = 1'b0;
      @(negedge clk);
   endtask

   // Response monitors: pop the expected entry on each ready pulse
   always @(negedge clk) begin
      if (ready) begin
         chk_eq("busy_with_ready", busy, 0);
         if (q2.size() == 0) begin
            chk_eq("unexpected_ready", ready, 0);
         end else begin
            m2 = q2.pop_front();
            chk_eq("rdata", rdata, m2.rdata);
`ifdef DM_BOUNDS_CHECK_EN
            chk_eq("err", err, m2.err);
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (ready0) begin
         chk_eq("busy0_with_ready", busy0, 0);
         if (q0.size() == 0) begin
            chk_eq("unexpected_ready0", ready0, 0);
         end else begin
            m0 = q0.pop_front();
            chk_eq("rdata0", rdata0, m0.rdata);
`ifdef DM_BOUNDS_CHECK_EN
            chk_eq("err0", err0, m0.err);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      en = 1'b0; wen = '0; addr = '0; wdata = '0;
      en0 = 1'b0; wen0 = '0; addr0 = '0; wdata0 = '0;
      last_rd = '0;
      vals[0] = 32'h11111111; vals[1] = 32'h2222_3333;
      vals[2] = 32'h4444_5555; vals[3] = 32'hCAFE_0003;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_eq("rst_ready", ready, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_rdata", rdata, 0);
      chk_eq("rst_ready0", ready0, 0);
      chk_eq("rst_rdata0", rdata0, 0);
`ifdef DM_BOUNDS_CHECK_EN
      chk_eq("rst_err", err, 0);
`endif

      // zero word 0, then read it back
      issue(4'hF, 32'h0, 32'h0, 0); idle();
      issue(4'h0, 32'h0, 32'h0, 0); idle();

      // full write, partial write, read-after-write, all back-to-back
      issue(4'hF,    32'h10, 32'hDEADBEEF, 0);
      issue(4'b0011, 32'h10, 32'h000055AA, 0);
      issue(4'h0,    32'h10, 32'h0, 0);
      idle();

      // reset arriving in WAIT at the would-be commit edge drops the write
      issue(4'hF, 32'h20, 32'hCAFEF00D, 0); idle();
      en = 1'b1; wen = 4'hF; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      chk_eq("abort_busy", busy, 1);
      @(negedge clk);
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk_eq("abort_busy_clr", busy, 0);
      chk_eq("abort_rdata_clr", rdata, 0);
      last_rd = '0;
      repeat (4) begin
         @(negedge clk);
         chk_eq("abort_no_ready", ready, 0);
      end
      issue(4'h0, 32'h20, 32'h0, 0); idle();

      // en dropped and re-raised with another write during WAIT is ignored
      issue(4'h0, 32'h20, 32'h0, 1); idle();
      issue(4'h0, 32'h10, 32'h0, 0); idle();

      // out-of-range access: suppressed with bounds checking, aliased without
      issue(4'hF, 32'h1000, 32'hA5A50001, 0); idle();
      issue(4'h0, 32'h1000, 32'h0, 0); idle();
      issue(4'h0, 32'h0, 32'h0, 0); idle();

      // random data, sustained back-to-back, read back in reverse order
      for (int i = 0; i < 8; i++) issue(4'hF, 32'h40 + 32'(4 * i), $urandom, 0);
      for (int i = 7; i >= 0; i--) issue(4'h0, 32'h40 + 32'(4 * i), 32'h0, 0);
      idle();

      // zero-wait-state instance: a response every cycle, in order
      en0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wen0 = 4'hF; addr0 = 32'(4 * i); wdata0 = vals[i];
         q0.push_back('{rdata: 32'h0, err: 1'b0});
         @(posedge clk);
         @(negedge clk);
         chk_eq("b2b_wr_ready0", ready0, 1);
      end
      for (int i = 0; i < 4; i++) begin
         wen0 = 4'h0; addr0 = 32'(4 * i); wdata0 = 32'h0;
         q0.push_back('{rdata: vals[i], err: 1'b0});
         @(posedge clk);
         @(negedge clk);
         chk_eq("b2b_rd_ready0", ready0, 1);
         chk_eq("b2b_rd_busy0", busy0, 0);
      end
      en0 = 1'b0;
      @(negedge clk);
      chk_eq("idle_ready0", ready0, 0);

      repeat (3) @(negedge clk);
      chk_eq("sb_empty", q2.size(), 0);
      chk_eq("sb0_empty", q0.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/dm_wait_ram.md
Name: dm_wait_ram

Overview:
- Data-memory responder for the CPU's data_sram-style initiator port (en / byte-enable wen / addr / wdata / rdata).
- Adds a ready handshake and a programmable wait-state counter, so the pipeline can be exercised against slow memory.
- Sits beside the CPU in the top level as an alternative responder to the single-cycle data memory; the CPU stalls until ready.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2, wait states between acceptance and response; 0..15 legal.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  request strobe; sampled only when the block can accept
- wen  input  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 4'b0000 means read
- addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data; valid in the ready cycle of a read
- ready  output  1  one-cycle response pulse
- busy  output  1  high while a request is outstanding (WAIT state)
- err  output  1  present only with DM_BOUNDS_CHECK_EN

Behaviour:
- Reset (synchronous, checked at the clock edge) forces:
  - state=IDLE, counter=0, ready=0, busy=0, rdata=32'h0, err=0.
  - Memory contents are not cleared.
  - A reset asserted during WAIT discards the pending request: no write is committed and no ready is produced.
- States: IDLE, WAIT, RESP.
- Acceptance: a request is accepted at an edge where en=1 and state is IDLE or RESP.
  - On acceptance, addr, wen and wdata are latched and the counter is loaded with WAIT_CYCLES.
  - en is ignored in WAIT. Requests arriving then are dropped; the initiator must hold en until ready.
- Transitions:
  - IDLE/RESP + accept: go to WAIT if WAIT_CYCLES>0, otherwise go directly to RESP.
  - IDLE/RESP + no accept: go to IDLE.
  - WAIT: counter decrements each cycle. At counter==1, go to RESP.
- Commit at the edge entering RESP:
  - Write: only bytes with latched wen=1 are updated; other bytes are preserved.
  - Read: rdata <= mem[index].
  - On a write, rdata holds its previous value.
- RESP lasts one cycle with ready=1.
- Latency: accept edge to ready cycle = WAIT_CYCLES+1 cycles.
- Back-to-back: a new request accepted in RESP produces its response exactly WAIT_CYCLES+1 cycles later. Sustained throughput is one transaction per WAIT_CYCLES+1 cycles.
- Read-after-write to the same word, issued back-to-back, returns the merged new data.
- busy=1 exactly in WAIT; ready=1 exactly in RESP; the two are never both high.
- The array is inferred as synchronous RAM: one read/write port, no asynchronous read.

Optional Feature:
- Macro: DM_BOUNDS_CHECK_EN.
- Defined:
  - err output exists.
  - A request with addr >= DEPTH_WORDS*4 still completes with the normal latency.
  - Out-of-range write: suppressed.
  - Out-of-range read: rdata=32'h0.
  - err=1 in that ready cycle only; otherwise err=0.
- Undefined:
  - No err port.
  - Upper address bits are ignored, so out-of-range addresses alias modulo the memory size.

Test Plan:
- Reset, then read of addr 0x0 with WAIT_CYCLES=2, en held: busy high for 2 cycles, then ready=1 on the 3rd cycle after acceptance; rdata=32'h0 if the bench preloads zero.
- Write 32'hDEADBEEF to 0x10 with wen=4'hF, then write 32'h000055AA with wen=4'b0011, then read 0x10: rdata=32'hDEAD55AA.
- WAIT_CYCLES=0, four back-to-back reads of 0x0/0x4/0x8/0xC: ready every cycle, data in order, each one cycle after its accept.
- Reset asserted during WAIT of a write of 32'h12345678 to 0x20: no ready pulse. A subsequent read of 0x20 returns the prior contents.
- en pulsed during WAIT with a different address: ignored; only the original request responds; busy/ready timing unchanged.
- With DM_BOUNDS_CHECK_EN, DEPTH_WORDS=1024: write to 0x1000 then read 0x1000 gives err=1 and rdata=0, and word 0 is unchanged. Without the macro, the same write lands in word 0.
